ee354_matrix_loader: RTL and testbench

EE354_MATRIX_LOADER -- requirements
Module: ee354_matrix_loader

---
 rtl/ee354_matrix_pkg.sv | 23 ++
 rtl/ee354_matrix_cursor.sv | 44 ++++
 rtl/ee354_matrix_loader.sv | 137 +++++++++++++
 tb/tb_ee354_matrix_loader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ee354_matrix_pkg.sv
// Shared definitions for the matrix loader: state encodings, legal parameter ranges, init pattern.
// Build option IDENTITY_INIT_EN selects an identity init pattern instead of all-zero.
package ee354_matrix_pkg;

    typedef enum logic [3:0] {
        ST_LOAD = 4'b0001,
        ST_FULL = 4'b0010,
        ST_LOCK = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;
    localparam int W_MIN = 1;
    localparam int W_MAX = 16;

`ifdef IDENTITY_INIT_EN
    localparam bit INIT_IDENTITY = 1'b1;
`else
    localparam bit INIT_IDENTITY = 1'b0;
`endif

endpackage

// File: rtl/ee354_matrix_cursor.sv
// Row-major write cursor over an N x N matrix; wrap flags the step from (N-1,N-1) back to (0,0).
// Latency: position updates on the edge after adv/clr; wrap is combinational.
// Backpressure: none, the caller decides when to advance.
module ee354_matrix_cursor #(
    parameter int N = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 clr,
    input  logic                 adv,
    output logic [$clog2(N)-1:0] row,
    output logic [$clog2(N)-1:0] col,
    output logic                 wrap
);
    import ee354_matrix_pkg::*;

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic col_last;
    logic row_last;

    assign col_last = (col == LAST);
    assign row_last = (row == LAST);
    assign wrap     = adv && col_last && row_last;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ee354_matrix_loader.sv
// Switch-driven N x N matrix loader with LOAD/FULL/LOCK/DONE handoff; init pattern set by IDENTITY_INIT_EN.
// Latency: writes land on the pulse edge; Rd_data is registered, one cycle after the address is sampled.
// Backpressure: none; Start/Ack pulse handshake, pulses in ignoring states are dropped.
module ee354_matrix_loader
    import ee354_matrix_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [W-1:0]         Sw,
    input  logic                 Enter,
    input  logic                 Skip,
    input  logic                 Clear,
    input  logic                 Start,
    input  logic                 Ack,
    input  logic [$clog2(N)-1:0] Rd_row,
    input  logic [$clog2(N)-1:0] Rd_col,
    output logic [W-1:0]         Rd_data,
    output logic [$clog2(N)-1:0] Cur_row,
    output logic [$clog2(N)-1:0] Cur_col,
    output logic                 q_Load,
    output logic                 q_Full,
    output logic                 q_Lock,
    output logic                 q_Done
);
    localparam int AW = $clog2(N);

    generate
        if (N < N_MIN || N > N_MAX || W < W_MIN || W > W_MAX) begin : g_bad_cfg
            $error("ee354_matrix_loader: N or W outside legal range");
        end
    endgenerate

    function automatic logic [W-1:0] init_val(input int r, input int c);
        return (INIT_IDENTITY && (r == c)) ? W'(1) : W'(0);
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] mem [N][N];
    logic         do_init, do_write, cur_clr, cur_adv, cur_wrap;
    logic         rd_in_range;

    ee354_matrix_cursor #(.N(N)) u_cursor (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (cur_clr),
        .adv     (cur_adv),
        .row     (Cur_row),
        .col     (Cur_col),
        .wrap    (cur_wrap)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_LOAD;
        else          state_q <= state_d;
    end

    // Priority Clear > Start > Enter > Skip; LOCK only listens to Ack.
    always_comb begin
        state_d  = state_q;
        do_init  = 1'b0;
        do_write = 1'b0;
        cur_clr  = 1'b0;
        cur_adv  = 1'b0;
        case (state_q)
            ST_LOAD, ST_FULL: begin
                if (Clear) begin
                    do_init = 1'b1;
                    cur_clr = 1'b1;
                    state_d = ST_LOAD;
                end else if (Start) begin
                    state_d = ST_LOCK;
                end else if (Enter) begin
                    do_write = 1'b1;
                    cur_adv  = 1'b1;
                end else if (Skip) begin
                    cur_adv = 1'b1;
                end
                if (cur_adv) begin
                    if (state_q == ST_FULL) state_d = ST_LOAD;
                    else if (cur_wrap)      state_d = ST_FULL;
                end
            end
            ST_LOCK: begin
                if (Ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (Clear) begin
                    do_init = 1'b1;
                    cur_clr = 1'b1;
                    state_d = ST_LOAD;
                end else if (Ack) begin
                    cur_clr = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mem[r][c] <= init_val(r, c);
        end else if (do_init) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mem[r][c] <= init_val(r, c);
        end else if (do_write) begin
            mem[Cur_row][Cur_col] <= Sw;
        end
    end

    // A power-of-two N leaves no address encoding outside the matrix.
    generate
        if ((1 << AW) == N) begin : g_rd_pow2
            assign rd_in_range = 1'b1;
        end else begin : g_rd_npow2
            assign rd_in_range = (Rd_row < AW'(N)) && (Rd_col < AW'(N));
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)         Rd_data <= '0;
        else if (rd_in_range) Rd_data <= mem[Rd_row][Rd_col];
        else                  Rd_data <= '0;
    end

    assign q_Load = state_q[0];
    assign q_Full = state_q[1];
    assign q_Lock = state_q[2];
    assign q_Done = state_q[3];

endmodule

// File: tb/tb_ee354_matrix_loader.sv
// Directed checks of the matrix loader at N=4 and N=3 (W=8) with hand-computed expectations.
module tb_ee354_matrix_loader;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;

    logic [7:0] Sw = '0;
    logic       Enter = 0, Skip = 0, Clear = 0, Start = 0, Ack = 0;
    logic [1:0] Rd_row = '0, Rd_col = '0;
    logic [7:0] Rd_data;
    logic [1:0] Cur_row, Cur_col;
    logic       q_Load, q_Full, q_Lock, q_Done;

    logic [7:0] Sw3 = '0;
    logic       Enter3 = 0, Skip3 = 0;
    logic [1:0] Rd_row3 = '0, Rd_col3 = '0;
    logic [7:0] Rd_data3;
    logic [1:0] Cur_row3, Cur_col3;
    logic       q_Load3, q_Full3, q_Lock3, q_Done3;

    int errs = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    ee354_matrix_loader #(.N(4), .W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Sw(Sw), .Enter(Enter), .Skip(Skip),
        .Clear(Clear), .Start(Start), .Ack(Ack), .Rd_row(Rd_row), .Rd_col(Rd_col),
        .Rd_data(Rd_data), .Cur_row(Cur_row), .Cur_col(Cur_col),
        .q_Load(q_Load), .q_Full(q_Full), .q_Lock(q_Lock), .q_Done(q_Done)
    );

    ee354_matrix_loader #(.N(3), .W(8)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .Sw(Sw3), .Enter(Enter3), .Skip(Skip3),
        .Clear(1'b0), .Start(1'b0), .Ack(1'b0), .Rd_row(Rd_row3), .Rd_col(Rd_col3),
        .Rd_data(Rd_data3), .Cur_row(Cur_row3), .Cur_col(Cur_col3),
        .q_Load(q_Load3), .q_Full(q_Full3), .q_Lock(q_Lock3), .q_Done(q_Done3)
    );

    function automatic logic [7:0] init_exp(input int r, input int c);
`ifdef IDENTITY_INIT_EN
        return (r == c) ? 8'd1 : 8'd0;
`else
        return (r == c) ? 8'd0 : 8'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] r, input logic [1:0] c);
        Rd_row = r;
        Rd_col = c;
        tick();
    endtask

    initial begin
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_state", {28'd0, q_Load, q_Full, q_Lock, q_Done}, 32'b1000);
        chk("rst_cursor", {Cur_row, Cur_col}, 0);
        chk("rst_rd_data", Rd_data, 0);
        #20 Reset_n = 1'b1;
        tick();

        rd(2'd1, 2'd1);
        chk("init_11", Rd_data, init_exp(1, 1));

        // Fill all 16 elements with 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            Sw = 8'h10 + 8'(i);
            Enter = 1;
            tick();
        end
        Enter = 0;
        chk("fill_full", {28'd0, q_Load, q_Full, q_Lock, q_Done}, 32'b0100);
        chk("fill_cursor", {Cur_row, Cur_col}, 0);
        rd(2'd2, 2'd3);
        chk("fill_rd_23", Rd_data, 8'h1B);
        rd(2'd0, 2'd0);
        chk("fill_rd_00", Rd_data, 8'h10);

        Skip = 1; tick(); Skip = 0;
        chk("full_skip_state", q_Load, 1);
        chk("full_skip_cursor", {Cur_row, Cur_col}, 4'b0001);
        Skip = 1;
        for (int i = 0; i < 14; i++) tick();
        Skip = 0;
        chk("skip_to_33", {Cur_row, Cur_col}, 4'b1111);

        Sw = 8'h99; Enter = 1; Start = 1; tick(); Enter = 0; Start = 0;
        chk("start_lock", q_Lock, 1);
        chk("start_cursor", {Cur_row, Cur_col}, 4'b1111);
        rd(2'd3, 2'd3);
        chk("start_33_kept", Rd_data, 8'h1F);

        Sw = 8'hAA; Enter = 1; tick(); Enter = 0;
        Clear = 1; tick(); Clear = 0;
        Skip = 1; tick(); Skip = 0;
        Start = 1; tick(); Start = 0;
        chk("lock_hold", q_Lock, 1);
        chk("lock_cursor", {Cur_row, Cur_col}, 4'b1111);
        rd(2'd3, 2'd3);
        chk("lock_33", Rd_data, 8'h1F);
        rd(2'd0, 2'd0);
        chk("lock_00", Rd_data, 8'h10);

        Ack = 1; tick(); Ack = 0;
        chk("ack_done", q_Done, 1);
        Start = 1; tick(); Start = 0;
        chk("done_start_ign", q_Done, 1);
        Ack = 1; tick(); Ack = 0;
        chk("ack_load", q_Load, 1);
        chk("ack_cursor", {Cur_row, Cur_col}, 0);
        rd(2'd1, 2'd2);
        chk("ack_kept_12", Rd_data, 8'h16);

        Rd_row = 0; Rd_col = 0; Sw = 8'h77; Enter = 1; tick(); Enter = 0;
        chk("rw_old", Rd_data, 8'h10);
        tick();
        chk("rw_new", Rd_data, 8'h77);
        chk("rw_cursor", {Cur_row, Cur_col}, 4'b0001);
        Ack = 1; tick(); Ack = 0;
        chk("load_ack_ign", q_Load, 1);

        Clear = 1; tick(); Clear = 0;
        chk("clr_state", q_Load, 1);
        chk("clr_cursor", {Cur_row, Cur_col}, 0);
        rd(2'd1, 2'd1);
        chk("clr_11", Rd_data, init_exp(1, 1));
        rd(2'd1, 2'd2);
        chk("clr_12", Rd_data, init_exp(1, 2));
        rd(2'd0, 2'd0);
        chk("clr_00", Rd_data, init_exp(0, 0));

        Sw = 8'h33; Clear = 1; Start = 1; Enter = 1; tick();
        Clear = 0; Start = 0; Enter = 0;
        chk("prio_state", q_Load, 1);
        chk("prio_cursor", {Cur_row, Cur_col}, 0);
        tick();
        chk("prio_00", Rd_data, init_exp(0, 0));

        Sw = 8'h42; Enter = 1; tick(); Enter = 0;
        Start = 1; tick(); Start = 0;
        chk("pre_rst_lock", q_Lock, 1);
        chk("pre_rst_rd", Rd_data, 8'h42);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_lock_state", {28'd0, q_Load, q_Full, q_Lock, q_Done}, 32'b1000);
        chk("rst_lock_rd", Rd_data, 0);
        chk("rst_lock_cursor", {Cur_row, Cur_col}, 0);
        #10 Reset_n = 1'b1;
        tick();
        rd(2'd0, 2'd0);
        chk("rst_mem_00", Rd_data, init_exp(0, 0));

        Skip3 = 1;
        for (int i = 0; i < 9; i++) tick();
        Skip3 = 0;
        chk("n3_full", q_Full3, 1);
        chk("n3_full_cursor", {Cur_row3, Cur_col3}, 0);
        Sw3 = 8'h55; Enter3 = 1; tick(); Enter3 = 0;
        chk("n3_load", q_Load3, 1);
        chk("n3_cursor", {Cur_row3, Cur_col3}, 4'b0001);
        Rd_row3 = 0; Rd_col3 = 0; tick();
        chk("n3_00", Rd_data3, 8'h55);
        Rd_row3 = 2'd3; Rd_col3 = 0; tick();
        chk("n3_oor_row", Rd_data3, 0);
        Rd_row3 = 0; Rd_col3 = 2'd3; tick();
        chk("n3_oor_col", Rd_data3, 0);
        Rd_row3 = 0; Rd_col3 = 0; tick();
        chk("n3_back_00", Rd_data3, 8'h55);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
